// File: rtl/time_entry_ctrl_if.sv
// Load bus from the time-entry front end to the alarm clock core.
// The writer side drives BCD digits plus the held load requests.
interface time_entry_ctrl_if;
  logic [1:0] Hour_in1;
  logic [3:0] Hour_in0;
  logic [3:0] Min_in1;
  logic [3:0] Min_in0;
  logic       Load_time;
  logic       Load_Alarm;

  modport master (
    output Hour_in1, Hour_in0, Min_in1, Min_in0, Load_time, Load_Alarm
  );

  modport slave (
    input Hour_in1, Hour_in0, Min_in1, Min_in0, Load_time, Load_Alarm
  );
endinterface

// File: rtl/time_entry_ctrl.sv
// Button-driven HH:MM editor: debounces four buttons, edits digits one field
// at a time and issues a held Load_time / Load_Alarm request to the clock core.
module time_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOAD_HOLD       = 24,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                btn_mode,
  input  logic                btn_next,
  input  logic                btn_inc,
  input  logic                btn_confirm,
  time_entry_ctrl_if.master   load_bus,
  output logic                edit_active,
  output logic                edit_alarm,
  output logic [1:0]          field_sel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(LOAD_HOLD + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOAD_HOLD - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_EDIT_TIME  = 2'd1;
  localparam logic [1:0] S_EDIT_ALARM = 2'd2;
  localparam logic [1:0] S_LOAD       = 2'd3;

  // Bit order for all button vectors: 0=mode, 1=next, 2=inc, 3=confirm.
  logic [3:0]    btn_raw;
  logic [3:0]    sync_p0;
  logic [3:0]    sync_p1;
  logic [3:0]    db_lvl;
  logic [3:0]    db_lvl_d;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    evt;

  logic [1:0]    state;
  logic          ld_alarm;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;

  logic [1:0]    h1;
  logic [3:0]    h0;
  logic [3:0]    m1;
  logic [3:0]    m0;

  logic [1:0]    h1_inc;
  logic [3:0]    h0_inc;
  logic [3:0]    m1_inc;
  logic [3:0]    m0_inc;
  logic          ev_confirm;
  logic          ev_mode;
  logic          ev_next;
  logic          ev_inc;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? 4'd0 : v + 4'd1;
  endfunction

  assign btn_raw = {btn_confirm, btn_inc, btn_next, btn_mode};

  // Stage p0/p1: two-flop synchroniser, then debounce counter per button
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign evt = db_lvl & ~db_lvl_d;

  always_comb begin
    ev_confirm = evt[3];
    ev_mode    = evt[0] & ~evt[3];
    ev_next    = evt[1] & ~evt[3] & ~evt[0];
    ev_inc     = evt[2] & ~evt[3] & ~evt[0] & ~evt[1];
    h1_inc     = (h1 == 2'd2) ? 2'd0 : h1 + 2'd1;
    h0_inc     = wrap_inc(h0, (h1 == 2'd2) ? 4'd3 : 4'd9);
    m1_inc     = wrap_inc(m1, 4'd5);
    m0_inc     = wrap_inc(m0, 4'd9);
  end

  // Stage p2: edit FSM, digit registers and load strobe timing
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      ld_alarm  <= 1'b0;
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
      field_sel <= 2'd0;
      h1        <= 2'd0;
      h0        <= 4'd0;
      m1        <= 4'd0;
      m0        <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_mode) begin
            state     <= S_EDIT_TIME;
            field_sel <= 2'd0;
            tmo_cnt   <= '0;
          end
        end
        S_EDIT_TIME, S_EDIT_ALARM: begin
          if (ev_confirm) begin
            state    <= S_LOAD;
            ld_alarm <= (state == S_EDIT_ALARM);
            hold_cnt <= '0;
          end else if (ev_mode) begin
            state     <= (state == S_EDIT_TIME) ? S_EDIT_ALARM : S_IDLE;
            field_sel <= (state == S_EDIT_TIME) ? 2'd0 : field_sel;
            tmo_cnt   <= '0;
          end else if (ev_next) begin
            field_sel <= field_sel + 2'd1;
            tmo_cnt   <= '0;
          end else if (ev_inc) begin
            tmo_cnt <= '0;
            case (field_sel)
              2'd0: begin
                h1 <= h1_inc;
                // Keep the hour legal when the tens digit rolls up to 2.
                if (h1_inc == 2'd2 && h0 > 4'd3) h0 <= 4'd3;
              end
              2'd1:    h0 <= h0_inc;
              2'd2:    m1 <= m1_inc;
              default: m0 <= m0_inc;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          if (hold_cnt == HOLD_LAST) state <= S_IDLE;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
      endcase
    end
  end

  assign edit_active         = (state == S_EDIT_TIME) || (state == S_EDIT_ALARM);
  assign edit_alarm          = (state == S_EDIT_ALARM);
  assign load_bus.Load_time  = (state == S_LOAD) && !ld_alarm;
  assign load_bus.Load_Alarm = (state == S_LOAD) && ld_alarm;
  assign load_bus.Hour_in1   = h1;
  assign load_bus.Hour_in0   = h0;
  assign load_bus.Min_in1    = m1;
  assign load_bus.Min_in0    = m0;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: table-driven edit vectors through a scoreboard
// queue, plus hand-written load, latency, reset-during-load and timeout cases.
module tb_time_entry_ctrl;
  localparam int DB   = 4;
  localparam int HOLD = 24;
  localparam int TMO  = 256;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;
  logic       edit_active;
  logic       edit_alarm;
  logic [1:0] field_sel;

  time_entry_ctrl_if bus();

  time_entry_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LOAD_HOLD(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .btn_mode(btns[0]),
    .btn_next(btns[1]),
    .btn_inc(btns[2]),
    .btn_confirm(btns[3]),
    .load_bus(bus),
    .edit_active(edit_active),
    .edit_alarm(edit_alarm),
    .field_sel(field_sel)
  );

  always #5 CLK = ~CLK;

  localparam int B_MODE = 0, B_NEXT = 1, B_INC = 2, B_CONF = 3;

  typedef struct {
    int btn;
    int reps;
    int fsel;
    int h1, h0, m1, m0;
    int act, alm;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int btn, int reps, int fsel, int h1, int h0,
                              int m1, int m0, int act, int alm);
    vec_t v;
    v.btn = btn; v.reps = reps; v.fsel = fsel;
    v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0;
    v.act = act; v.alm = alm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input int h1, input int h0, input int m1, input int m0);
    chk($sformatf("%s.h1", tag), 32'(bus.Hour_in1), 32'(h1));
    chk($sformatf("%s.h0", tag), 32'(bus.Hour_in0), 32'(h0));
    chk($sformatf("%s.m1", tag), 32'(bus.Min_in1), 32'(m1));
    chk($sformatf("%s.m0", tag), 32'(bus.Min_in0), 32'(m0));
  endtask

  task automatic check_state(input vec_t e, input string tag);
    chk_digits(tag, e.h1, e.h0, e.m1, e.m0);
    chk($sformatf("%s.fsel", tag), 32'(field_sel), 32'(e.fsel));
    chk($sformatf("%s.active", tag), 32'(edit_active), 32'(e.act));
    chk($sformatf("%s.alarm", tag), 32'(edit_alarm), 32'(e.alm));
    chk($sformatf("%s.ld_time", tag), 32'(bus.Load_time), 32'd0);
    chk($sformatf("%s.ld_alarm", tag), 32'(bus.Load_Alarm), 32'd0);
  endtask

  // Clean press: 8 cycles high, 8 cycles low, enough for both debounce edges.
  task automatic press(input logic [3:0] mask);
    @(posedge CLK); #1 btns = mask;
    repeat (8) @(posedge CLK);
    #1 btns = 4'b0000;
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i <= hi; i++) begin
      sb.push_back(tbl[i]);
      for (int r = 0; r < tbl[i].reps; r++) press(4'(1 << tbl[i].btn));
      e = sb.pop_front();
      check_state(e, $sformatf("vec%0d", i));
    end
  endtask

  // Raise the given buttons and watch the strobe; rst_at>0 asserts reset on
  // that strobe cycle and checks the cleared outputs instead of the full window.
  task automatic load_seq(input logic [3:0] mask, input bit exp_alarm, input int rst_at,
                          input int h1, input int h0, input int m1, input int m0,
                          input string tag);
    int   seen  = -1;
    int   hi    = 0;
    bit   other = 1'b0;
    bit   did_rst = 1'b0;
    logic strobe;
    @(posedge CLK); #1 btns = mask;
    for (int c = 0; c < 80; c++) begin
      @(posedge CLK); #1;
      if (c == 8) btns = 4'b0000;
      strobe = exp_alarm ? bus.Load_Alarm : bus.Load_time;
      other  = other | (exp_alarm ? bus.Load_time : bus.Load_Alarm);
      if (strobe) begin
        if (seen < 0) begin
          seen = c;
          chk($sformatf("%s.active_on_load", tag), 32'(edit_active), 32'd0);
          chk($sformatf("%s.alarm_on_load", tag), 32'(edit_alarm), 32'd0);
          chk_digits($sformatf("%s.load", tag), h1, h0, m1, m0);
        end
        hi++;
        if (rst_at > 0 && hi == rst_at) begin
          reset = 1'b1;
          @(posedge CLK); #1 reset = 1'b0;
          chk($sformatf("%s.rst_ld_time", tag), 32'(bus.Load_time), 32'd0);
          chk($sformatf("%s.rst_ld_alarm", tag), 32'(bus.Load_Alarm), 32'd0);
          chk_digits($sformatf("%s.rst", tag), 0, 0, 0, 0);
          chk($sformatf("%s.rst_active", tag), 32'(edit_active), 32'd0);
          chk($sformatf("%s.rst_fsel", tag), 32'(field_sel), 32'd0);
          did_rst = 1'b1;
          break;
        end
      end
    end
    btns = 4'b0000;
    chk($sformatf("%s.latency", tag), 32'(seen), 32'd6);
    chk($sformatf("%s.other_strobe", tag), 32'(other), 32'd0);
    if (rst_at > 0) begin
      chk($sformatf("%s.reset_hit", tag), 32'(did_rst), 32'd1);
      repeat (20) @(posedge CLK);
      #1;
    end else begin
      chk($sformatf("%s.hold", tag), 32'(hi), 32'(HOLD));
      chk($sformatf("%s.end_active", tag), 32'(edit_active), 32'd0);
      chk($sformatf("%s.end_ld", tag), 32'(bus.Load_time | bus.Load_Alarm), 32'd0);
    end
  endtask

  initial begin
    int fall;
    bit ld_seen;

    // A: from EDIT_TIME 00:00, field 0
    tbl.push_back(mk(B_INC,  2, 0, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(B_NEXT, 1, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC,  5, 1, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_NEXT, 1, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC,  6, 2, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_NEXT, 1, 3, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC, 10, 3, 2, 1, 0, 0, 1, 0));
    // B: from IDLE 21:00 -- clamp, alarm entry/abort, set 06:30 in EDIT_ALARM
    tbl.push_back(mk(B_MODE, 1, 0, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC,  2, 0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_NEXT, 1, 1, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC,  8, 1, 1, 9, 0, 0, 1, 0));
    tbl.push_back(mk(B_NEXT, 3, 0, 1, 9, 0, 0, 1, 0));
    tbl.push_back(mk(B_INC,  1, 0, 2, 3, 0, 0, 1, 0));
    tbl.push_back(mk(B_MODE, 1, 0, 2, 3, 0, 0, 1, 1));
    tbl.push_back(mk(B_MODE, 1, 0, 2, 3, 0, 0, 0, 0));
    tbl.push_back(mk(B_MODE, 1, 0, 2, 3, 0, 0, 1, 0));
    tbl.push_back(mk(B_MODE, 1, 0, 2, 3, 0, 0, 1, 1));
    tbl.push_back(mk(B_INC,  1, 0, 0, 3, 0, 0, 1, 1));
    tbl.push_back(mk(B_NEXT, 1, 1, 0, 3, 0, 0, 1, 1));
    tbl.push_back(mk(B_INC,  3, 1, 0, 6, 0, 0, 1, 1));
    tbl.push_back(mk(B_NEXT, 1, 2, 0, 6, 0, 0, 1, 1));
    tbl.push_back(mk(B_INC,  3, 2, 0, 6, 3, 0, 1, 1));
    // C: from IDLE 06:30 into EDIT_TIME
    tbl.push_back(mk(B_MODE, 1, 0, 0, 6, 3, 0, 1, 0));
    // D: after reset, enter EDIT_TIME
    tbl.push_back(mk(B_MODE, 1, 0, 0, 0, 0, 0, 1, 0));

    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    chk_digits("reset", 0, 0, 0, 0);
    chk("reset.ld_time", 32'(bus.Load_time), 32'd0);
    chk("reset.ld_alarm", 32'(bus.Load_Alarm), 32'd0);
    chk("reset.active", 32'(edit_active), 32'd0);
    chk("reset.alarm", 32'(edit_alarm), 32'd0);
    chk("reset.fsel", 32'(field_sel), 32'd0);

    // 3-cycle glitch must not register
    @(posedge CLK); #1 btns = 4'b0100;
    repeat (3) @(posedge CLK);
    #1 btns = 4'b0000;
    repeat (12) @(posedge CLK);
    #1;
    chk_digits("glitch", 0, 0, 0, 0);
    chk("glitch.active", 32'(edit_active), 32'd0);

    // 10-cycle mode press: edit_active exactly 7 cycles after the raw rise
    @(posedge CLK); #1 btns = 4'b0001;
    repeat (6) @(posedge CLK);
    #1 chk("mode_lat.c6", 32'(edit_active), 32'd0);
    @(posedge CLK);
    #1 chk("mode_lat.c7", 32'(edit_active), 32'd1);
    chk("mode_lat.fsel", 32'(field_sel), 32'd0);
    chk("mode_lat.alarm", 32'(edit_alarm), 32'd0);
    repeat (3) @(posedge CLK);
    #1 btns = 4'b0000;
    repeat (10) @(posedge CLK);
    #1;

    run_vecs(0, 6);
    load_seq(4'b1000, 1'b0, 0, 2, 1, 0, 0, "ld_time");
    run_vecs(7, 21);
    load_seq(4'b1000, 1'b1, 0, 0, 6, 3, 0, "ld_alarm");
    run_vecs(22, 22);
    load_seq(4'b1100, 1'b0, 10, 0, 6, 3, 0, "conf_inc_rst");
    run_vecs(23, 23);

    // Idle in EDIT_TIME until the timeout returns to IDLE without a strobe
    fall = -1;
    ld_seen = 1'b0;
    for (int c = 0; c < TMO + 50; c++) begin
      @(posedge CLK); #1;
      ld_seen = ld_seen | bus.Load_time | bus.Load_Alarm;
      if (!edit_active && fall < 0) fall = c;
    end
    chk("timeout.fell", 32'(fall >= TMO - 20 && fall <= TMO), 32'd1);
    chk("timeout.no_strobe", 32'(ld_seen), 32'd0);
    chk("timeout.alarm", 32'(edit_alarm), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
